axi_rd_responder: RTL and testbench

AXI_RD_RESPONDER -- requirements
Module: axi_rd_responder

---
 rtl/axi_rd_responder.sv | 146 ++++++++++++++
 tb/tb_axi_rd_responder.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_responder.sv
// axi_rd_responder: AXI read-channel slave in front of a single-port SRAM
// with one cycle of read latency. Each beat takes 3 cycles: ADDR drives the
// SRAM, WAIT captures the returned word, and RESP presents it until it is
// accepted. Supported bursts are FIXED and INCR over a 14-bit word address
// that wraps at 2^14.
// Optional feature macro: RD_ERR_CHECK_EN. When it is defined, requests with
// ARSIZE != 4 bytes or a burst type of 2'b10/2'b11 are answered with SLVERR
// beats and the SRAM is not accessed. When it is undefined, ARSIZE is
// ignored and burst types 2'b10/2'b11 behave as INCR.
module axi_rd_responder #(
    parameter int unsigned AXI_IDS_BITS = 8
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [AXI_IDS_BITS-1:0] ARID,
    input  logic [31:0]             ARADDR,
    input  logic [3:0]              ARLEN,
    input  logic [2:0]              ARSIZE,
    input  logic [1:0]              ARBURST,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    output logic [AXI_IDS_BITS-1:0] RID,
    output logic [31:0]             RDATA,
    output logic [1:0]              RRESP,
    output logic                    RLAST,
    output logic                    RVALID,
    input  logic                    RREADY,
    output logic                    mem_cs,
    output logic                    mem_oe,
    output logic [13:0]             mem_addr,
    input  logic [31:0]             mem_dout
);

    localparam int unsigned WA_W   = 14;
    localparam int unsigned LEN_W  = 4;
    localparam int unsigned DATA_W = 32;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t            state;
    logic [WA_W-1:0]   addr_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  beat_cnt;
    logic              incr_q;
    logic              err_q;
    logic [WA_W-1:0]   next_addr;
    logic              req_err;
    logic              req_incr;
    logic              unused_bits;

    // Request classification: legality check and burst type decode.
`ifdef RD_ERR_CHECK_EN
    assign req_err     = (ARSIZE != 3'b010) || ARBURST[1];
    assign req_incr    = (ARBURST == 2'b01);
    assign unused_bits = ^{ARADDR[31:16], ARADDR[1:0]};
`else
    assign req_err     = 1'b0;
    assign req_incr    = (ARBURST != 2'b00);
    assign unused_bits = ^{ARSIZE, ARADDR[31:16], ARADDR[1:0]};
`endif

    // Accept requests only while idle, independent of ARVALID.
    assign ARREADY = (state == IDLE);

    // Word address of the following beat; INCR wraps naturally at 2^14.
    always_comb begin
        next_addr = addr_q;
        if (incr_q) begin
            next_addr = addr_q + WA_W'(1);
        end
    end

    // Beat sequencer with registered AXI and SRAM outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            addr_q   <= '0;
            len_q    <= '0;
            beat_cnt <= '0;
            incr_q   <= 1'b0;
            err_q    <= 1'b0;
            RID      <= '0;
            RDATA    <= '0;
            RRESP    <= RESP_OKAY;
            RLAST    <= 1'b0;
            RVALID   <= 1'b0;
            mem_cs   <= 1'b0;
            mem_oe   <= 1'b0;
            mem_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ARVALID && ARREADY) begin
                        RID      <= ARID;
                        addr_q   <= ARADDR[15:2];
                        len_q    <= ARLEN;
                        incr_q   <= req_incr;
                        err_q    <= req_err;
                        beat_cnt <= '0;
                        mem_cs   <= ~req_err;
                        mem_oe   <= ~req_err;
                        mem_addr <= ARADDR[15:2];
                        state    <= ADDR;
                    end
                end
                ADDR: begin
                    mem_cs <= 1'b0;
                    mem_oe <= 1'b0;
                    state  <= WAIT;
                end
                WAIT: begin
                    RDATA  <= err_q ? DATA_W'(0) : mem_dout;
                    RRESP  <= err_q ? RESP_SLVERR : RESP_OKAY;
                    RLAST  <= (beat_cnt == len_q);
                    RVALID <= 1'b1;
                    state  <= RESP;
                end
                RESP: begin
                    if (RREADY) begin
                        RVALID <= 1'b0;
                        RLAST  <= 1'b0;
                        if (RLAST) begin
                            state <= IDLE;
                        end else begin
                            beat_cnt <= beat_cnt + LEN_W'(1);
                            addr_q   <= next_addr;
                            mem_addr <= next_addr;
                            mem_cs   <= ~err_q;
                            mem_oe   <= ~err_q;
                            state    <= ADDR;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_rd_responder.sv
// Scoreboard bench for axi_rd_responder: stimulus pushes expected beats and
// SRAM word addresses; a negedge monitor pops and compares them.
module tb_axi_rd_responder;

    typedef struct {
        logic [7:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    logic        clk;
    logic        rstn;
    logic [7:0]  ARID;
    logic [31:0] ARADDR;
    logic [3:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic        ARVALID;
    logic        ARREADY;
    logic [7:0]  RID;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY;
    logic        mem_cs;
    logic        mem_oe;
    logic [13:0] mem_addr;
    logic [31:0] mem_dout;

    logic [31:0] mem [0:16383];

    beat_t       exp_q[$];
    logic [13:0] maddr_q[$];

    int n_chk  = 0;
    int n_pass = 0;

    axi_rd_responder #(.AXI_IDS_BITS(8)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .ARID     (ARID),
        .ARADDR   (ARADDR),
        .ARLEN    (ARLEN),
        .ARSIZE   (ARSIZE),
        .ARBURST  (ARBURST),
        .ARVALID  (ARVALID),
        .ARREADY  (ARREADY),
        .RID      (RID),
        .RDATA    (RDATA),
        .RRESP    (RRESP),
        .RLAST    (RLAST),
        .RVALID   (RVALID),
        .RREADY   (RREADY),
        .mem_cs   (mem_cs),
        .mem_oe   (mem_oe),
        .mem_addr (mem_addr),
        .mem_dout (mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: data valid the cycle after the address is presented.
    always @(posedge clk) begin
        if (mem_cs && mem_oe) begin
            mem_dout <= mem[mem_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic exp_beat(input logic [7:0] id, input logic [31:0] data,
                            input logic [1:0] resp, input logic last);
        beat_t b;
        b.id = id; b.data = data; b.resp = resp; b.last = last;
        exp_q.push_back(b);
    endtask

    task automatic exp_mem(input logic [13:0] a);
        maddr_q.push_back(a);
    endtask

    // Monitor: checks reset values, SRAM addresses, beat latency, stability and content.
    int          cyc = 0;
    int          ref_cyc = 0;
    int          rdy_chk = -1;
    bit          in_beat = 1'b0;
    logic [7:0]  cap_id;
    logic [31:0] cap_data;
    logic [1:0]  cap_resp;
    logic        cap_last;

    always @(negedge clk) begin
        beat_t       b;
        logic [13:0] ea;
        cyc++;
        if (!rstn) begin
            chk("rst_rvalid", 32'(RVALID), 32'd0);
            chk("rst_rlast", 32'(RLAST), 32'd0);
            chk("rst_rid", 32'(RID), 32'd0);
            chk("rst_rdata", RDATA, 32'd0);
            chk("rst_rresp", 32'(RRESP), 32'd0);
            chk("rst_mem_cs", 32'({mem_cs, mem_oe}), 32'd0);
            chk("rst_mem_addr", 32'(mem_addr), 32'd0);
            in_beat = 1'b0;
            rdy_chk = -1;
        end else begin
            if (cyc == rdy_chk) begin
                chk("arready_after_last", 32'(ARREADY), 32'd1);
            end
            if (ARVALID && ARREADY) begin
                ref_cyc = cyc;
            end
            if (mem_cs) begin
                chk("mem_oe", 32'(mem_oe), 32'd1);
                if (maddr_q.size() == 0) begin
                    chk("mem_cs_unexpected", 32'(mem_cs), 32'd0);
                end else begin
                    ea = maddr_q.pop_front();
                    chk("mem_addr", 32'(mem_addr), 32'(ea));
                end
            end
            if (RVALID) begin
                if (!in_beat) begin
                    chk("beat_latency", 32'(cyc - ref_cyc), 32'd3);
                    cap_id = RID; cap_data = RDATA; cap_resp = RRESP; cap_last = RLAST;
                    in_beat = 1'b1;
                end else begin
                    chk("hold_rid", 32'(RID), 32'(cap_id));
                    chk("hold_rdata", RDATA, cap_data);
                    chk("hold_rresp", 32'(RRESP), 32'(cap_resp));
                    chk("hold_rlast", 32'(RLAST), 32'(cap_last));
                end
                if (RREADY) begin
                    if (exp_q.size() == 0) begin
                        chk("beat_unexpected", 32'(RVALID), 32'd0);
                    end else begin
                        b = exp_q.pop_front();
                        chk("rid", 32'(RID), 32'(b.id));
                        chk("rdata", RDATA, b.data);
                        chk("rresp", 32'(RRESP), 32'(b.resp));
                        chk("rlast", 32'(RLAST), 32'(b.last));
                    end
                    if (RLAST) begin
                        rdy_chk = cyc + 1;
                    end
                    ref_cyc = cyc;
                    in_beat = 1'b0;
                end
            end
        end
    end

    // Issue one AR request once the slave is idle; returns just after the handshake edge.
    task automatic send(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                        input logic [2:0] size, input logic [1:0] burst);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (ARREADY) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            chk("arready_timeout", 32'(ARREADY), 32'd1);
        end
        ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst;
        ARVALID = 1'b1;
        @(posedge clk); #1;
        ARVALID = 1'b0;
    endtask

    // Wait until every expected beat and SRAM access has been observed.
    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (exp_q.size() == 0 && maddr_q.size() == 0 && ARREADY) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            chk("drain_timeout", 32'(exp_q.size() + maddr_q.size()), 32'd0);
            exp_q.delete();
            maddr_q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
        mem[14'h0004] = 32'hDEADBEEF;
        mem[14'h0040] = 32'h11111111;
        mem[14'h0041] = 32'h22222222;
        mem[14'h0042] = 32'h33333333;
        mem[14'h0043] = 32'h44444444;
        mem[14'h3FFF] = 32'hCAFEF00D;
        mem[14'h0000] = 32'h0BADC0DE;
        mem[14'h0008] = 32'h87654321;
        mem[14'h000C] = 32'hC0C0C0C0;
        mem[14'h000D] = 32'hD0D0D0D0;
        mem[14'h0080] = 32'hA0A0A0A0;
        mem[14'h0081] = 32'hB1B1B1B1;

        rstn = 1'b0; ARVALID = 1'b0; ARID = '0; ARADDR = '0; ARLEN = '0;
        ARSIZE = 3'b010; ARBURST = 2'b01; RREADY = 1'b1;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        chk("arready_after_reset", 32'(ARREADY), 32'd1);

        // Single beat, ARLEN=0.
        exp_mem(14'h0004);
        exp_beat(8'h15, 32'hDEADBEEF, 2'b00, 1'b1);
        send(8'h15, 32'h0000_0010, 4'd0, 3'b010, 2'b01);
        wait_done();

        // INCR burst of four.
        exp_mem(14'h0040); exp_mem(14'h0041); exp_mem(14'h0042); exp_mem(14'h0043);
        exp_beat(8'h22, 32'h11111111, 2'b00, 1'b0);
        exp_beat(8'h22, 32'h22222222, 2'b00, 1'b0);
        exp_beat(8'h22, 32'h33333333, 2'b00, 1'b0);
        exp_beat(8'h22, 32'h44444444, 2'b00, 1'b1);
        send(8'h22, 32'h0000_0100, 4'd3, 3'b010, 2'b01);
        wait_done();

        // INCR wrap at top word with backpressure on beat 0.
        exp_mem(14'h3FFF); exp_mem(14'h0000);
        exp_beat(8'h3C, 32'hCAFEF00D, 2'b00, 1'b0);
        exp_beat(8'h3C, 32'h0BADC0DE, 2'b00, 1'b1);
        RREADY = 1'b0;
        send(8'h3C, 32'h0000_FFFC, 4'd1, 3'b010, 2'b01);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (RVALID) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk("stall_rvalid_timeout", 32'(RVALID), 32'd1);
        repeat (5) @(posedge clk);
        #1 RREADY = 1'b1;
        wait_done();

        // FIXED burst of three.
        exp_mem(14'h0008); exp_mem(14'h0008); exp_mem(14'h0008);
        exp_beat(8'h47, 32'h87654321, 2'b00, 1'b0);
        exp_beat(8'h47, 32'h87654321, 2'b00, 1'b0);
        exp_beat(8'h47, 32'h87654321, 2'b00, 1'b1);
        send(8'h47, 32'h0000_0020, 4'd2, 3'b010, 2'b00);
        wait_done();

        // Illegal size: SLVERR with checking, normal data without.
`ifdef RD_ERR_CHECK_EN
        exp_beat(8'h51, 32'h0, 2'b10, 1'b0);
        exp_beat(8'h51, 32'h0, 2'b10, 1'b1);
`else
        exp_mem(14'h0080); exp_mem(14'h0081);
        exp_beat(8'h51, 32'hA0A0A0A0, 2'b00, 1'b0);
        exp_beat(8'h51, 32'hB1B1B1B1, 2'b00, 1'b1);
`endif
        send(8'h51, 32'h0000_0200, 4'd1, 3'b001, 2'b01);
        wait_done();

        // Reserved burst type 2'b11.
`ifdef RD_ERR_CHECK_EN
        exp_beat(8'h5E, 32'h0, 2'b10, 1'b0);
        exp_beat(8'h5E, 32'h0, 2'b10, 1'b1);
`else
        exp_mem(14'h0080); exp_mem(14'h0081);
        exp_beat(8'h5E, 32'hA0A0A0A0, 2'b00, 1'b0);
        exp_beat(8'h5E, 32'hB1B1B1B1, 2'b00, 1'b1);
`endif
        send(8'h5E, 32'h0000_0200, 4'd1, 3'b010, 2'b11);
        wait_done();

        // Second request while busy must not be accepted.
        exp_mem(14'h000C); exp_mem(14'h000D);
        exp_beat(8'h66, 32'hC0C0C0C0, 2'b00, 1'b0);
        exp_beat(8'h66, 32'hD0D0D0D0, 2'b00, 1'b1);
        send(8'h66, 32'h0000_0030, 4'd1, 3'b010, 2'b01);
        ARID = 8'h99; ARADDR = 32'hFFFF_FFFF; ARLEN = 4'd7; ARVALID = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("busy_arready", 32'(ARREADY), 32'd0);
            @(posedge clk); #1;
        end
        ARVALID = 1'b0;
        wait_done();

        // Reset pulsed during WAIT of beat 0 aborts the burst.
        exp_mem(14'h0010);
        send(8'h77, 32'h0000_0040, 4'd3, 3'b010, 2'b01);
        @(posedge clk); #1;
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        repeat (12) @(posedge clk);
        @(negedge clk);
        chk("rst_no_beat_pending", 32'(RVALID), 32'd0);
        chk("rst_mem_q_empty", 32'(maddr_q.size()), 32'd0);
        chk("rst_idle", 32'(ARREADY), 32'd1);

        // Normal operation after the aborted burst.
        exp_mem(14'h0004);
        exp_beat(8'h08, 32'hDEADBEEF, 2'b00, 1'b1);
        send(8'h08, 32'h0000_0010, 4'd0, 3'b010, 2'b01);
        wait_done();
        repeat (3) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
